// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR unit: CSR addresses, operation
// encodings, mstatus/mie/mip bit positions and the read-modify-write helper.
package csr_pkg;

    typedef logic [1:0] csr_op_t;

    localparam csr_op_t CSR_OP_NONE = 2'b00;
    localparam csr_op_t CSR_OP_RW   = 2'b01;
    localparam csr_op_t CSR_OP_RS   = 2'b10;
    localparam csr_op_t CSR_OP_RC   = 2'b11;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    localparam int MI_MSI = 3;
    localparam int MI_MTI = 7;
    localparam int MI_MEI = 11;

    localparam logic [31:0] MI_WRITE_MASK = (32'h1 << MI_MEI) | (32'h1 << MI_MTI) | (32'h1 << MI_MSI);

    function automatic logic [31:0] csr_apply_op(input csr_op_t op,
                                                 input logic [31:0] old_val,
                                                 input logic [31:0] wdata);
        logic [31:0] result;
        case (op)
            CSR_OP_RW: result = wdata;
            CSR_OP_RS: result = old_val | wdata;
            CSR_OP_RC: result = old_val & ~wdata;
            default:   result = old_val;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/csr_if.sv
// CSR access bus between the EX stage (master) and the CSR unit (slave).
interface csr_if
    import csr_pkg::*;
#(
    parameter int XLEN = 32
);

    logic [11:0]     csr_addr;
    csr_op_t         csr_op;
    logic [XLEN-1:0] csr_wdata;
    logic            csr_wr_suppress;
    logic [XLEN-1:0] csr_rdata;
    logic            csr_illegal;

    modport master (
        output csr_addr,
        output csr_op,
        output csr_wdata,
        output csr_wr_suppress,
        input  csr_rdata,
        input  csr_illegal
    );

    modport slave (
        input  csr_addr,
        input  csr_op,
        input  csr_wdata,
        input  csr_wr_suppress,
        output csr_rdata,
        output csr_illegal
    );

endinterface

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with increment enable and independent
// write enables for the low and high halves.
module csr_counter64
    import csr_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        inc_en,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [63:0] count
);

    logic [63:0] count_q;
    logic [63:0] count_d;

    // A software write to either half takes the place of the increment for that cycle.
    always_comb begin
        count_d = count_q;
        if (wr_lo || wr_hi) begin
            if (wr_lo) count_d[31:0]  = wdata;
            if (wr_hi) count_d[63:32] = wdata;
        end else if (inc_en) begin
            count_d = count_q + 64'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR unit: Zicsr read-modify-write, illegal-access detection,
// trap entry / mret, optional mcycle/minstret counters (macro CSR_COUNTERS_EN).
module csr_unit
    import csr_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] HART_ID     = '0,
    parameter logic [XLEN-1:0] MTVEC_RESET = '0,
    parameter logic [XLEN-1:0] MISA_VAL    = 32'h4000_0100
) (
    input  logic            clk,
    input  logic            reset,
    csr_if.slave            bus,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_pc,
    input  logic [XLEN-1:0] trap_tval,
    input  logic            mret,
    input  logic            instr_retire,
    input  logic            irq_ext,
    input  logic            irq_timer,
    input  logic            irq_sw,
    output logic [XLEN-1:0] mtvec_out,
    output logic [XLEN-1:0] mepc_out,
    output logic            irq_pending
);

    logic            mstatus_mie_q,  mstatus_mie_d;
    logic            mstatus_mpie_q, mstatus_mpie_d;
    logic [XLEN-1:0] mie_q,      mie_d;
    logic [XLEN-1:0] mtvec_q,    mtvec_d;
    logic [XLEN-1:0] mscratch_q, mscratch_d;
    logic [XLEN-1:0] mepc_q,     mepc_d;
    logic [XLEN-1:0] mcause_q,   mcause_d;
    logic [XLEN-1:0] mtval_q,    mtval_d;

    logic [XLEN-1:0] mstatus_val;
    logic [XLEN-1:0] mip_val;
    logic [XLEN-1:0] old_val;
    logic [XLEN-1:0] new_val;
    logic            implemented;
    logic            op_active;
    logic            wr_attempt;
    logic            illegal;
    logic            wr_en;

`ifdef CSR_COUNTERS_EN
    logic [63:0] mcycle;
    logic [63:0] minstret;
    logic        wr_mcycle_lo,   wr_mcycle_hi;
    logic        wr_minstret_lo, wr_minstret_hi;

    assign wr_mcycle_lo   = wr_en && (bus.csr_addr == CSR_MCYCLE);
    assign wr_mcycle_hi   = wr_en && (bus.csr_addr == CSR_MCYCLEH);
    assign wr_minstret_lo = wr_en && (bus.csr_addr == CSR_MINSTRET);
    assign wr_minstret_hi = wr_en && (bus.csr_addr == CSR_MINSTRETH);

    csr_counter64 u_mcycle (
        .clk    (clk),
        .reset  (reset),
        .inc_en (1'b1),
        .wr_lo  (wr_mcycle_lo),
        .wr_hi  (wr_mcycle_hi),
        .wdata  (new_val),
        .count  (mcycle)
    );

    csr_counter64 u_minstret (
        .clk    (clk),
        .reset  (reset),
        .inc_en (instr_retire),
        .wr_lo  (wr_minstret_lo),
        .wr_hi  (wr_minstret_hi),
        .wdata  (new_val),
        .count  (minstret)
    );
`else
    logic unused_instr_retire;
    assign unused_instr_retire = instr_retire;
`endif

    // Architectural views: MPP is hardwired to M-mode, mip mirrors the live irq lines.
    always_comb begin
        mstatus_val = '0;
        mstatus_val[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        mstatus_val[MSTATUS_MPIE] = mstatus_mpie_q;
        mstatus_val[MSTATUS_MIE]  = mstatus_mie_q;

        mip_val = '0;
        mip_val[MI_MEI] = irq_ext;
        mip_val[MI_MTI] = irq_timer;
        mip_val[MI_MSI] = irq_sw;
    end

    always_comb begin
        implemented = 1'b1;
        old_val     = '0;
        case (bus.csr_addr)
            CSR_MSTATUS:   old_val = mstatus_val;
            CSR_MISA:      old_val = MISA_VAL;
            CSR_MIE:       old_val = mie_q;
            CSR_MTVEC:     old_val = mtvec_q;
            CSR_MSCRATCH:  old_val = mscratch_q;
            CSR_MEPC:      old_val = mepc_q;
            CSR_MCAUSE:    old_val = mcause_q;
            CSR_MTVAL:     old_val = mtval_q;
            CSR_MIP:       old_val = mip_val;
            CSR_MHARTID:   old_val = HART_ID;
`ifdef CSR_COUNTERS_EN
            CSR_MCYCLE:    old_val = mcycle[31:0];
            CSR_MCYCLEH:   old_val = mcycle[63:32];
            CSR_MINSTRET:  old_val = minstret[31:0];
            CSR_MINSTRETH: old_val = minstret[63:32];
`endif
            default:       implemented = 1'b0;
        endcase
    end

    // Address space 0xC00-0xFFF is read-only; only a real write attempt there faults.
    always_comb begin
        op_active  = (bus.csr_op != CSR_OP_NONE);
        wr_attempt = op_active && !bus.csr_wr_suppress;
        illegal    = op_active && (!implemented || ((bus.csr_addr[11:10] == 2'b11) && wr_attempt));
        wr_en      = wr_attempt && !illegal && !trap_valid;
        new_val    = csr_apply_op(bus.csr_op, old_val, bus.csr_wdata);
    end

    assign bus.csr_rdata   = illegal ? '0 : old_val;
    assign bus.csr_illegal = illegal;

    // Later assignments override earlier ones: trap beats mret beats the CSR write.
    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_d          = mie_q;
        mtvec_d        = mtvec_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mtval_d        = mtval_q;

        if (wr_en) begin
            case (bus.csr_addr)
                CSR_MSTATUS: begin
                    mstatus_mie_d  = new_val[MSTATUS_MIE];
                    mstatus_mpie_d = new_val[MSTATUS_MPIE];
                end
                CSR_MIE:      mie_d      = new_val & MI_WRITE_MASK;
                CSR_MTVEC:    mtvec_d    = {new_val[XLEN-1:2], 2'b00};
                CSR_MSCRATCH: mscratch_d = new_val;
                CSR_MEPC:     mepc_d     = {new_val[XLEN-1:2], 2'b00};
                CSR_MCAUSE:   mcause_d   = new_val;
                CSR_MTVAL:    mtval_d    = new_val;
                default: ;
            endcase
        end

        if (mret) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end

        if (trap_valid) begin
            mepc_d         = {trap_pc[XLEN-1:2], 2'b00};
            mcause_d       = trap_cause;
            mtval_d        = trap_tval;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= '0;
            mtvec_q        <= MTVEC_RESET;
            mscratch_q     <= '0;
            mepc_q         <= '0;
            mcause_q       <= '0;
            mtval_q        <= '0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_q          <= mie_d;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mtval_q        <= mtval_d;
        end
    end

    assign mtvec_out   = mtvec_q;
    assign mepc_out    = mepc_q;
    assign irq_pending = mstatus_mie_q && |(mip_val & mie_q);

endmodule

// File: tb/tb_csr_unit.sv
// Self-checking bench for csr_unit: directed steps followed by randomized
// traffic, all compared against an architectural model of the M-mode CSRs.
module tb_csr_unit;

    localparam logic [31:0] HART      = 32'h0000_0005;
    localparam logic [31:0] MTVEC_RST = 32'h0000_0080;
    localparam logic [31:0] MISA      = 32'h4000_0100;
`ifdef CSR_COUNTERS_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        trap_valid, mret, instr_retire, irq_ext, irq_timer, irq_sw;
    logic [31:0] trap_cause, trap_pc, trap_tval;
    logic [31:0] mtvec_out, mepc_out;
    logic        irq_pending;

    int passed = 0;
    int total  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    csr_if #(.XLEN(32)) bus ();

    csr_unit #(
        .XLEN        (32),
        .HART_ID     (HART),
        .MTVEC_RESET (MTVEC_RST),
        .MISA_VAL    (MISA)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .trap_valid   (trap_valid),
        .trap_cause   (trap_cause),
        .trap_pc      (trap_pc),
        .trap_tval    (trap_tval),
        .mret         (mret),
        .instr_retire (instr_retire),
        .irq_ext      (irq_ext),
        .irq_timer    (irq_timer),
        .irq_sw       (irq_sw),
        .mtvec_out    (mtvec_out),
        .mepc_out     (mepc_out),
        .irq_pending  (irq_pending)
    );

    // Architectural model state
    bit          m_mie, m_mpie;
    logic [31:0] m_mie_reg, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
    logic [63:0] m_cycle, m_instret;

    logic [11:0] addr_pool [16] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                                    12'h342, 12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02,
                                    12'hB82, 12'hF14, 12'h7C0, 12'hC00};

    function void model_reset();
        m_mie = 0; m_mpie = 0;
        m_mie_reg = 0; m_mtvec = MTVEC_RST; m_mscratch = 0;
        m_mepc = 0; m_mcause = 0; m_mtval = 0;
        m_cycle = 0; m_instret = 0;
    endfunction

    function bit model_impl(input logic [11:0] a);
        case (a)
            12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
            12'h342, 12'h343, 12'h344, 12'hF14: return 1'b1;
            12'hB00, 12'hB80, 12'hB02, 12'hB82: return CNT_EN;
            default: return 1'b0;
        endcase
    endfunction

    function logic [31:0] model_mip();
        return (32'(irq_ext) << 11) | (32'(irq_timer) << 7) | (32'(irq_sw) << 3);
    endfunction

    function logic [31:0] model_old(input logic [11:0] a);
        case (a)
            12'h300: return 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
            12'h301: return MISA;
            12'h304: return m_mie_reg;
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h343: return m_mtval;
            12'h344: return model_mip();
            12'hB00: return CNT_EN ? m_cycle[31:0] : 32'h0;
            12'hB80: return CNT_EN ? m_cycle[63:32] : 32'h0;
            12'hB02: return CNT_EN ? m_instret[31:0] : 32'h0;
            12'hB82: return CNT_EN ? m_instret[63:32] : 32'h0;
            12'hF14: return HART;
            default: return 32'h0;
        endcase
    endfunction

    function bit model_illegal();
        logic [11:0] a;
        a = bus.csr_addr;
        if (bus.csr_op == 2'b00) return 1'b0;
        return !model_impl(a) || (a[11:10] == 2'b11 && !bus.csr_wr_suppress);
    endfunction

    function logic [31:0] model_rdata();
        return model_illegal() ? 32'h0 : model_old(bus.csr_addr);
    endfunction

    function bit model_irq();
        return m_mie && ((model_mip() & m_mie_reg) != 32'h0);
    endfunction

    // One clock edge of architectural behaviour, using the inputs held across it.
    function void model_edge();
        logic [11:0] a;
        logic [31:0] oldv, nv, wd;
        bit          wr, cyc_wr, ins_wr;
        a      = bus.csr_addr;
        wd     = bus.csr_wdata;
        oldv   = model_old(a);
        wr     = bus.csr_op != 2'b00 && !bus.csr_wr_suppress && !model_illegal() && !trap_valid;
        nv     = (bus.csr_op == 2'b01) ? wd : (bus.csr_op == 2'b10) ? (oldv | wd) : (oldv & ~wd);
        cyc_wr = 0;
        ins_wr = 0;
        if (wr) begin
            case (a)
                12'h300: if (!mret) begin m_mie = nv[3]; m_mpie = nv[7]; end
                12'h304: m_mie_reg = nv & 32'h0000_0888;
                12'h305: m_mtvec = nv & ~32'h3;
                12'h340: m_mscratch = nv;
                12'h341: m_mepc = nv & ~32'h3;
                12'h342: m_mcause = nv;
                12'h343: m_mtval = nv;
                12'hB00: begin m_cycle[31:0]    = nv; cyc_wr = 1; end
                12'hB80: begin m_cycle[63:32]   = nv; cyc_wr = 1; end
                12'hB02: begin m_instret[31:0]  = nv; ins_wr = 1; end
                12'hB82: begin m_instret[63:32] = nv; ins_wr = 1; end
                default: ;
            endcase
        end
        if (trap_valid) begin
            m_mepc   = trap_pc & ~32'h3;
            m_mcause = trap_cause;
            m_mtval  = trap_tval;
            m_mpie   = m_mie;
            m_mie    = 0;
        end else if (mret) begin
            m_mie  = m_mpie;
            m_mpie = 1;
        end
        if (CNT_EN) begin
            if (!cyc_wr) m_cycle = m_cycle + 64'd1;
            if (!ins_wr && instr_retire) m_instret = m_instret + 64'd1;
        end
    endfunction

    task automatic applyStimulus(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd,
                                 input bit sup, input bit tv, input bit mr);
        bus.csr_addr        = a;
        bus.csr_op          = op;
        bus.csr_wdata       = wd;
        bus.csr_wr_suppress = sup;
        trap_valid          = tv;
        mret                = mr;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else begin
            failed = failed + 1;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic sample_all(input string tag);
        @(negedge clk);
        checkOutput({tag, ".rdata"},   bus.csr_rdata,          model_rdata());
        checkOutput({tag, ".illegal"}, 32'(bus.csr_illegal),   32'(model_illegal()));
        checkOutput({tag, ".irq"},     32'(irq_pending),       32'(model_irq()));
        checkOutput({tag, ".mtvec"},   mtvec_out,              m_mtvec);
        checkOutput({tag, ".mepc"},    mepc_out,               m_mepc);
    endtask

    task automatic clock_edge();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        applyStimulus(12'h000, 2'b00, 32'h0, 0, 0, 0);
        instr_retire = 0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 0;
        idle();
        clock_edge();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        idle();
        irq_ext = 0; irq_timer = 0; irq_sw = 0;
        trap_cause = 0; trap_pc = 0; trap_tval = 0;
        model_reset();
        repeat (2) @(posedge clk);
        release_reset();

        // Reset values
        applyStimulus(12'h305, 2'b10, 32'h0, 1, 0, 0);
        sample_all("rst_mtvec");
        checkOutput("rst_mtvec.const", bus.csr_rdata, MTVEC_RST);
        clock_edge();
        applyStimulus(12'h300, 2'b10, 32'h0, 1, 0, 0);
        sample_all("rst_mstatus");
        checkOutput("rst_mstatus.const", bus.csr_rdata, 32'h0000_1800);
        clock_edge();
        applyStimulus(12'hF14, 2'b10, 32'h0, 1, 0, 0);
        sample_all("rst_hartid");
        checkOutput("rst_hartid.const", bus.csr_rdata, HART);
        clock_edge();

        // RW / RS / RC on mscratch
        applyStimulus(12'h340, 2'b01, 32'hDEAD_BEEF, 0, 0, 0); sample_all("rw_scratch"); clock_edge();
        applyStimulus(12'h340, 2'b10, 32'h0000_0010, 0, 0, 0); sample_all("rs_scratch");
        checkOutput("rs_scratch.const", bus.csr_rdata, 32'hDEAD_BEEF); clock_edge();
        applyStimulus(12'h340, 2'b11, 32'h0000_000F, 0, 0, 0); sample_all("rc_scratch");
        checkOutput("rc_scratch.const", bus.csr_rdata, 32'hDEAD_BEFF); clock_edge();
        applyStimulus(12'h340, 2'b10, 32'h0, 1, 0, 0); sample_all("rd_scratch");
        checkOutput("rd_scratch.const", bus.csr_rdata, 32'hDEAD_BEF0); clock_edge();

        // mtvec low bits forced to zero
        applyStimulus(12'h305, 2'b01, 32'h0000_1003, 0, 0, 0); sample_all("wr_mtvec"); clock_edge();
        idle(); sample_all("mtvec_out");
        checkOutput("mtvec_out.const", mtvec_out, 32'h0000_1000); clock_edge();

        // Illegal accesses
        applyStimulus(12'hF14, 2'b01, 32'h1234_5678, 0, 0, 0); sample_all("wr_hartid");
        checkOutput("wr_hartid.const", 32'(bus.csr_illegal), 32'h1); clock_edge();
        applyStimulus(12'h7C0, 2'b01, 32'h1, 0, 0, 0); sample_all("unimpl");
        checkOutput("unimpl.const", 32'(bus.csr_illegal), 32'h1); clock_edge();
        applyStimulus(12'hF14, 2'b10, 32'h0, 1, 0, 0); sample_all("rs_hartid_sup");
        checkOutput("rs_hartid_sup.const", 32'(bus.csr_illegal), 32'h0); clock_edge();

        // Interrupt enable, trap entry and mret
        applyStimulus(12'h300, 2'b10, 32'h0000_0008, 0, 0, 0); sample_all("set_mie"); clock_edge();
        applyStimulus(12'h304, 2'b01, 32'h0000_0800, 0, 0, 0); sample_all("wr_mie"); clock_edge();
        irq_ext = 1; idle(); sample_all("irq_ext");
        checkOutput("irq_ext.const", 32'(irq_pending), 32'h1); clock_edge();
        trap_pc = 32'h0000_0100; trap_cause = 32'h8000_000B; trap_tval = 32'h0;
        applyStimulus(12'h000, 2'b00, 32'h0, 0, 1, 0); sample_all("trap"); clock_edge();
        applyStimulus(12'h300, 2'b10, 32'h0, 1, 0, 0); sample_all("post_trap");
        checkOutput("post_trap.mstatus", bus.csr_rdata, 32'h0000_1880);
        checkOutput("post_trap.mepc", mepc_out, 32'h0000_0100); clock_edge();
        applyStimulus(12'h342, 2'b10, 32'h0, 1, 0, 0); sample_all("mcause");
        checkOutput("mcause.const", bus.csr_rdata, 32'h8000_000B); clock_edge();
        applyStimulus(12'h300, 2'b10, 32'h0, 1, 0, 1); sample_all("mret"); clock_edge();
        applyStimulus(12'h300, 2'b10, 32'h0, 1, 0, 0); sample_all("post_mret");
        checkOutput("post_mret.const", bus.csr_rdata, 32'h0000_1888); clock_edge();

        // Same-cycle collisions
        applyStimulus(12'h300, 2'b01, 32'h0, 0, 0, 1); sample_all("mret_vs_wr"); clock_edge();
        applyStimulus(12'h300, 2'b10, 32'h0, 1, 0, 0); sample_all("mret_vs_wr_rd");
        checkOutput("mret_vs_wr.const", bus.csr_rdata, 32'h0000_1888); clock_edge();
        trap_pc = 32'h0000_0206;
        applyStimulus(12'h340, 2'b01, 32'h0000_1234, 0, 1, 0); sample_all("trap_vs_wr"); clock_edge();
        applyStimulus(12'h340, 2'b10, 32'h0, 1, 0, 0); sample_all("trap_vs_wr_rd");
        checkOutput("trap_vs_wr.scratch", bus.csr_rdata, 32'hDEAD_BEF0);
        checkOutput("trap_vs_wr.mepc", mepc_out, 32'h0000_0204); clock_edge();
        irq_ext = 0;

        // Counters
`ifdef CSR_COUNTERS_EN
        applyStimulus(12'hB00, 2'b01, 32'hFFFF_FFFF, 0, 0, 0); sample_all("wr_mcycle"); clock_edge();
        applyStimulus(12'hB80, 2'b01, 32'hFFFF_FFFF, 0, 0, 0); sample_all("wr_mcycleh"); clock_edge();
        applyStimulus(12'hB00, 2'b10, 32'h0, 1, 0, 0); sample_all("mcycle_max");
        checkOutput("mcycle_max.const", bus.csr_rdata, 32'hFFFF_FFFF); clock_edge();
        applyStimulus(12'hB00, 2'b10, 32'h0, 1, 0, 0); sample_all("mcycle_wrap");
        checkOutput("mcycle_wrap.const", bus.csr_rdata, 32'h0); clock_edge();
        instr_retire = 1;
        applyStimulus(12'hB02, 2'b01, 32'h0000_0005, 0, 0, 0); sample_all("wr_minstret"); clock_edge();
        applyStimulus(12'hB02, 2'b10, 32'h0, 1, 0, 0); sample_all("minstret_hold");
        checkOutput("minstret_hold.const", bus.csr_rdata, 32'h5); clock_edge();
        applyStimulus(12'hB02, 2'b10, 32'h0, 1, 0, 0); sample_all("minstret_inc");
        checkOutput("minstret_inc.const", bus.csr_rdata, 32'h6); clock_edge();
        instr_retire = 0;
`else
        applyStimulus(12'hB00, 2'b01, 32'hFFFF_FFFF, 0, 0, 0); sample_all("no_mcycle");
        checkOutput("no_mcycle.const", 32'(bus.csr_illegal), 32'h1); clock_edge();
        applyStimulus(12'hB82, 2'b10, 32'h0, 1, 0, 0); sample_all("no_minstreth");
        checkOutput("no_minstreth.const", 32'(bus.csr_illegal), 32'h1); clock_edge();
`endif

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            logic [1:0] op;
            bit         sup, tv, mr;
            op  = 2'($urandom_range(0, 3));
            sup = (op >= 2'b10) && ($urandom_range(0, 3) == 0);
            tv  = ($urandom_range(0, 11) == 0);
            if (tv) op = 2'b00;
            mr  = !tv && ($urandom_range(0, 9) == 0);
            trap_pc      = $urandom;
            trap_cause   = $urandom;
            trap_tval    = $urandom;
            instr_retire = 1'($urandom_range(0, 1));
            irq_ext      = 1'($urandom_range(0, 1));
            irq_timer    = 1'($urandom_range(0, 1));
            irq_sw       = 1'($urandom_range(0, 1));
            applyStimulus(addr_pool[$urandom_range(0, 15)], op,
                          ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : $urandom, sup, tv, mr);
            sample_all("rand");
            clock_edge();
        end

        // Asynchronous reset while a write to mepc is in flight
        idle(); irq_ext = 0; irq_timer = 0; irq_sw = 0;
        applyStimulus(12'h341, 2'b01, 32'hABCD_0004, 0, 0, 0);
        sample_all("pre_reset");
        #2;
        reset = 1;
        model_reset();
        #1;
        checkOutput("async_reset.mepc", mepc_out, 32'h0);
        checkOutput("async_reset.mtvec", mtvec_out, MTVEC_RST);
        @(posedge clk);
        release_reset();
        applyStimulus(12'h341, 2'b10, 32'h0, 1, 0, 0);
        sample_all("post_reset");
        checkOutput("post_reset.const", bus.csr_rdata, 32'h0);
        clock_edge();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/csr_unit.md
# csr_unit

Parametrised machine-mode CSR unit for the EX stage, replacing the flat 4096-entry CSR array with a sparse, architecturally correct set of M-mode registers. It executes Zicsr read-modify-write operations, flags illegal accesses, runs 64-bit cycle and instret counters, and performs trap entry and `mret` state updates. The read path is combinational; all state updates occur on the clock edge.

## Interface
- `XLEN`, 32: datapath width; only 32 is supported.
- `HART_ID`, 0: value returned by `mhartid`.
- `MTVEC_RESET`, 32'h0000_0000: reset value of `mtvec`.
- `MISA_VAL`, 32'h4000_0100: value returned by `misa` (RV32I).
---
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high reset
- `csr_addr`  in  12  CSR address
- `csr_op`  in  2  operation: 00 none, 01 RW, 10 RS, 11 RC
- `csr_wdata`  in  XLEN  source operand (rs1 or zero-extended immediate, resolved upstream)
- `csr_wr_suppress`  in  1  set for RS/RC with rs1/uimm = 0; the access is a read only
- `csr_rdata`  out  XLEN  old CSR value (combinational)
- `csr_illegal`  out  1  access is illegal (combinational)
- `trap_valid`  in  1  take a trap this cycle
- `trap_cause`, `trap_pc`, `trap_tval`  in  XLEN each  trap cause, trap PC, and trap value
- `mret`  in  1  return from trap
- `instr_retire`  in  1  one instruction retires this cycle
- `irq_ext`, `irq_timer`, `irq_sw`  in  1 each  interrupt level inputs
- `mtvec_out`, `mepc_out`  out  XLEN each  current `mtvec` and `mepc`, for the PC mux
- `irq_pending`  out  1  `mstatus.MIE & |(mip & mie)`

## Operation
- Implemented CSRs: `mstatus` 0x300, `misa` 0x301, `mie` 0x304, `mtvec` 0x305, `mscratch` 0x340, `mepc` 0x341, `mcause` 0x342, `mtval` 0x343, `mip` 0x344, `mcycle`/`mcycleh` 0xB00/0xB80, `minstret`/`minstreth` 0xB02/0xB82, `mhartid` 0xF14.
- New value per op: RW → `wdata`; RS → `old | wdata`; RC → `old & ~wdata`.
- A write occurs when all of the following hold: `csr_op != 0`, `!csr_wr_suppress`, `!csr_illegal`, and `!trap_valid`.
- `csr_illegal` is asserted when `csr_op != 0` and either:
  - the address is not implemented, or
  - `csr_addr[11:10] == 2'b11` and a write would occur.
- When `csr_illegal` is set, `csr_rdata` is 0 and no state changes.
- Field masks:
  - `mstatus`: only MIE[3] and MPIE[7] are writable; MPP[12:11] always reads 2'b11; all other bits read 0.
  - `mie`: only bits 11, 7, 3 are writable.
  - `mip`: reads `{irq_ext,…,irq_timer,…,irq_sw}` at bits 11/7/3; writes are ignored without being flagged illegal.
  - `mtvec[1:0]` and `mepc[1:0]` are forced to 0.
- Trap entry (`trap_valid`):
  - `mepc ← trap_pc`, `mcause ← trap_cause`, `mtval ← trap_tval`.
  - `MPIE ← MIE`, then `MIE ← 0`.
- `mret`: `MIE ← MPIE`, `MPIE ← 1`.
- Priority: `trap_valid` > `mret` > CSR write.
- Counters:
  - `mcycle` (64-bit) increments every cycle.
  - `minstret` increments when `instr_retire` is high.
  - Both wrap from 2^64−1 to 0.
  - A write to either half replaces that half, and that counter does not increment in that cycle; the other half holds.
- Reset values: every register is 0 except `mtvec` = `MTVEC_RESET`. `csr_illegal` is 0 and `irq_pending` is 0.

## Timing
- Read: `csr_rdata` and `csr_illegal` are valid in the same cycle as `csr_addr`/`csr_op`. The value returned is always the pre-write value.
- Write, trap, and mret effects are visible on `csr_rdata`, `mtvec_out`, and `mepc_out` in the cycle after the edge.
- `irq_pending` is combinational from the current `mstatus`/`mie` and the live irq inputs.
- Reset mid-operation: all state clears immediately (asynchronous). Any pending write is lost.
- `trap_valid` together with a CSR write in the same cycle: the write is dropped and the trap is taken.
- `mret` together with a write to `mstatus` in the same cycle: the `mret` result wins.

## Configuration
- `CSR_COUNTERS_EN` defined: `mcycle`, `mcycleh`, `minstret`, and `minstreth` are implemented as described above.
- `CSR_COUNTERS_EN` undefined:
  - the counter registers are removed and `instr_retire` is ignored;
  - addresses 0xB00, 0xB80, 0xB02, and 0xB82 are unimplemented, so any access to them raises `csr_illegal`.

## Structure
- Shared package `csr_pkg` holds:
  - CSR address localparams;
  - `csr_op` encodings;
  - the `mstatus` bit indices (MIE, MPIE, MPP);
  - the `mie`/`mip` bit indices.
- One sub-module, `csr_counter64`: a 64-bit counter with increment enable and per-half write-enable. It is instantiated twice under `CSR_COUNTERS_EN`.

## Test plan
- Reset, then read 0x305 → `MTVEC_RESET`; read 0x300 → 0x0000_1800; read 0xF14 → `HART_ID`.
- RW 0x340 with 0xDEAD_BEEF, then RS with 0x0000_0010, then RC with 0x0000_000F → reads return 0xDEAD_BEEF, then 0xDEAD_BEFF, and the final value is 0xDEAD_BEF0.
- Write 0xF14, and access 0x7C0 → `csr_illegal`=1 with no state change. RS to 0xF14 with `csr_wr_suppress`=1 → legal, returns `HART_ID`.
- Set MIE=1 and `mie`=0x800, then raise `irq_ext` → `irq_pending`=1.
  - `trap_valid` with pc 0x100 and cause 0x8000_000B → `mepc`=0x100, MIE=0, MPIE=1.
  - `mret` → MIE=1.
- Write `mcycle` with 0xFFFF_FFFF and `mcycleh` with 0xFFFF_FFFF → two cycles later `mcycle` reads 0. With `CSR_COUNTERS_EN` off, the same access → `csr_illegal`=1.
- Assert `reset` asynchronously while an RW to 0x341 is in flight → `mepc` reads 0 and no write occurs.
